// File: rtl/bcd_pkg.sv
// Shared widths and scanner state type for the BCD digit scanner slice.
package bcd_pkg;
  localparam int BCD_W = 4;
  localparam int DEC_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } state_e;
endpackage

// File: rtl/bcd_decode_1of10.sv
// Combinational BCD nibble to one-hot decimal decoder; nibbles above 9 give all-zero plus err.
module bcd_decode_1of10
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] nibble_i,
  output logic [DEC_W-1:0] dec_o,
  output logic             err_o
);

  always_comb begin
    dec_o = '0;
    for (int unsigned n = 0; n < DEC_W; n++) begin
      dec_o[n] = (nibble_i == BCD_W'(n));
    end
    err_o = (nibble_i > BCD_W'(9));
  end

endmodule

// File: rtl/bcd_digit_scanner.sv
// Time-multiplexed scanner: latches a packed BCD word, then shows each digit for DWELL
// cycles through one shared decoder, with one blank cycle between digits.
module bcd_digit_scanner
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DWELL  = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BCD_W*DIGITS-1:0] in_bcd,
  input  logic                    stop,
  output logic [DIGITS-1:0]       dig_sel,
  output logic [DEC_W-1:0]        dec_out,
  output logic                    bcd_err,
  output logic                    frame_done
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [BCD_W*DIGITS-1:0]   word_q, word_d;
  logic [DIGITS-1:0]         dig_sel_q, dig_sel_d;
  logic [DEC_W-1:0]          dec_q, dec_d;
  logic                      err_q, err_d;
  logic                      fd_q, fd_d;
  logic                      accept;
  logic [BCD_W-1:0]          nibble;
  logic [DEC_W-1:0]          dec_raw;
  logic                      err_raw;

  assign in_ready = (state_q == IDLE) || ((state_q == BLANK) && (idx_q == IDX_LAST));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    word_d  = accept ? in_bcd : word_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHOW;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == CNT_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BLANK: begin
        if (idx_q != IDX_LAST) begin
          idx_d   = idx_q + IW'(1);
          state_d = SHOW;
        end else begin
          idx_d   = '0;
          state_d = stop ? IDLE : SHOW;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so decode from next-state values to show a digit the cycle after it is chosen.
  assign nibble = word_d[idx_d*BCD_W +: BCD_W];

  bcd_decode_1of10 u_dec (
    .nibble_i (nibble),
    .dec_o    (dec_raw),
    .err_o    (err_raw)
  );

  always_comb begin
    dig_sel_d = '0;
    dec_d     = '0;
    err_d     = 1'b0;
    fd_d      = (state_d == BLANK) && (idx_d == IDX_LAST);
    if (state_d == SHOW) begin
      dig_sel_d = DIGITS'(1) << idx_d;
      dec_d     = dec_raw;
      err_d     = err_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      dig_sel_q <= '0;
      dec_q     <= '0;
      err_q     <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      dig_sel_q <= dig_sel_d;
      dec_q     <= dec_d;
      err_q     <= err_d;
      fd_q      <= fd_d;
    end
  end

  assign dig_sel    = dig_sel_q;
  assign dec_out    = dec_q;
  assign bcd_err    = err_q;
  assign frame_done = fd_q;

endmodule
